// File: rtl/branch_predictor_if.sv
// Fetch/execute bus between the pipeline and the branch predictor.
// The pipeline side drives fetch PC and resolved-branch updates; the
// predictor side returns predict/mispredict redirects and statistics.
interface branch_predictor_if #(
    parameter int WIDTH = 32
);
    // Fetch-side lookup
    logic [WIDTH-1:0] PCF;
    logic             en;
    logic             pc_predict_redirect_o;
    logic [WIDTH-1:0] predicted_target_pc_o;
    logic             pred_taken_F_o;

    // Execute-side resolution and training
    logic             update_valid_i;
    logic [WIDTH-1:0] update_pc_i;
    logic [WIDTH-1:0] update_pc_plus4_i;
    logic             update_is_jump_i;
    logic             update_taken_i;
    logic [WIDTH-1:0] update_target_i;
    logic             update_pred_taken_i;
    logic [WIDTH-1:0] update_pred_target_i;
    logic             pc_redirect_o;
    logic [WIDTH-1:0] mispredict_target_pc_o;

    // Statistics
    logic [31:0]      branch_count_o;
    logic [31:0]      mispredict_count_o;

    modport master (
        output PCF, en,
        output update_valid_i, update_pc_i, update_pc_plus4_i, update_is_jump_i,
        output update_taken_i, update_target_i, update_pred_taken_i, update_pred_target_i,
        input  pc_predict_redirect_o, predicted_target_pc_o, pred_taken_F_o,
        input  pc_redirect_o, mispredict_target_pc_o,
        input  branch_count_o, mispredict_count_o
    );

    modport slave (
        input  PCF, en,
        input  update_valid_i, update_pc_i, update_pc_plus4_i, update_is_jump_i,
        input  update_taken_i, update_target_i, update_pred_taken_i, update_pred_target_i,
        output pc_predict_redirect_o, predicted_target_pc_o, pred_taken_F_o,
        output pc_redirect_o, mispredict_target_pc_o,
        output branch_count_o, mispredict_count_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating
// direction counters, execute-side mispredict detection and training,
// and branch/mispredict statistics.
module branch_predictor #(
    parameter int WIDTH    = 32,
    parameter int ENTRIES  = 16,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input logic          clk,
    input logic          rst_n,
    branch_predictor_if.slave bp
);
    localparam int TAG_W = WIDTH - IDX_BITS - 2;

    // Table state, one element per BTB entry
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [WIDTH-3:0] target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic             jump_q   [ENTRIES];

    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    // Fetch lookup
    logic [IDX_BITS-1:0] idx_f;
    logic [TAG_W-1:0]    tag_f;
    logic                hit_f;
    logic                pred_taken;

    // Execute update
    logic [IDX_BITS-1:0] idx_u;
    logic [TAG_W-1:0]    tag_u;
    logic                hit_u;
    logic [WIDTH-1:0]    target_aligned;
    logic                mispredict;
    logic                redirect;

    assign idx_f = bp.PCF[IDX_BITS+1:2];
    assign tag_f = bp.PCF[WIDTH-1:IDX_BITS+2];
    assign idx_u = bp.update_pc_i[IDX_BITS+1:2];
    assign tag_u = bp.update_pc_i[WIDTH-1:IDX_BITS+2];
    assign target_aligned = {bp.update_target_i[WIDTH-1:2], 2'b00};

    // Lookup of the fetch PC against registered (pre-update) table state
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and infers a latch.
        hit_f                    = 1'b0;
        pred_taken               = 1'b0;
        bp.predicted_target_pc_o = '0;
        if (valid_q[idx_f] && (tag_q[idx_f] == tag_f)) begin
            hit_f                    = 1'b1;
            pred_taken               = jump_q[idx_f] || ctr_q[idx_f][1];
            bp.predicted_target_pc_o = {target_q[idx_f], 2'b00};
        end
    end

    // Resolve the executed branch against what fetch predicted
    always_comb begin
        mispredict                = 1'b0;
        redirect                  = 1'b0;
        bp.mispredict_target_pc_o = '0;
        hit_u                     = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
        mispredict = (bp.update_pred_taken_i != bp.update_taken_i) ||
                     (bp.update_pred_taken_i && bp.update_taken_i &&
                      (bp.update_pred_target_i != target_aligned));
        redirect = bp.update_valid_i && mispredict;
        if (redirect) begin
            bp.mispredict_target_pc_o = bp.update_taken_i ? target_aligned
                                                          : bp.update_pc_plus4_i;
        end
    end

    // A mispredict redirect always wins over a same-cycle prediction
    assign bp.pc_redirect_o         = redirect;
    assign bp.pred_taken_F_o        = pred_taken;
    assign bp.pc_predict_redirect_o = pred_taken && bp.en && !redirect;
    assign bp.branch_count_o        = branch_count_q;
    assign bp.mispredict_count_o    = mispredict_count_q;

    // Table training and statistics; reset clears all learned state
    always_ff @(posedge clk) begin
        // NOTE: the BTB arrays are reset explicitly because a reset must
        // discard all training, so this table cannot map to a plain RAM.
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                // NOTE: non-blocking assignments keep every register sampling
                // its pre-edge inputs, independent of statement order.
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
                jump_q[i]   <= 1'b0;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (bp.update_valid_i) begin
            branch_count_q <= branch_count_q + 32'd1;
            if (redirect) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
            if (hit_u) begin
                if (bp.update_taken_i) begin
                    if (ctr_q[idx_u] != 2'b11) ctr_q[idx_u] <= ctr_q[idx_u] + 2'd1;
                    target_q[idx_u] <= bp.update_target_i[WIDTH-1:2];
                    jump_q[idx_u]   <= bp.update_is_jump_i;
                end else if (ctr_q[idx_u] != 2'b00) begin
                    ctr_q[idx_u] <= ctr_q[idx_u] - 2'd1;
                end
            end else if (bp.update_taken_i) begin
                valid_q[idx_u]  <= 1'b1;
                tag_q[idx_u]    <= tag_u;
                target_q[idx_u] <= bp.update_target_i[WIDTH-1:2];
                ctr_q[idx_u]    <= 2'b10;
                jump_q[idx_u]   <= bp.update_is_jump_i;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: hand-computed expectations for
// reset, training, mispredict detection, aliasing, jumps, stall and reset.
module tb_branch_predictor;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    branch_predictor_if #(.WIDTH(WIDTH)) bp_if ();

    branch_predictor #(.WIDTH(WIDTH), .ENTRIES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
        end
    endtask

    task automatic set_update(input logic valid, input logic [WIDTH-1:0] pc,
                              input logic taken, input logic [WIDTH-1:0] target,
                              input logic is_jump, input logic pred_taken,
                              input logic [WIDTH-1:0] pred_target);
        bp_if.update_valid_i       = valid;
        bp_if.update_pc_i          = pc;
        bp_if.update_pc_plus4_i    = pc + 32'd4;
        bp_if.update_taken_i       = taken;
        bp_if.update_target_i      = target;
        bp_if.update_is_jump_i     = is_jump;
        bp_if.update_pred_taken_i  = pred_taken;
        bp_if.update_pred_target_i = pred_target;
    endtask

    task automatic no_update();
        set_update(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Let the pending inputs be captured by one rising edge, then settle
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check_lookup(input string name, input logic [WIDTH-1:0] pc,
                                input logic redir, input logic [WIDTH-1:0] tgt,
                                input logic taken_f);
        bp_if.PCF = pc;
        #1;
        check({name, "_redir"}, WIDTH'(bp_if.pc_predict_redirect_o), WIDTH'(redir));
        check({name, "_tgt"}, bp_if.predicted_target_pc_o, tgt);
        check({name, "_takenF"}, WIDTH'(bp_if.pred_taken_F_o), WIDTH'(taken_f));
    endtask

    task automatic check_counts(input string name, input logic [31:0] br,
                                input logic [31:0] mis);
        check({name, "_branch_cnt"}, bp_if.branch_count_o, br);
        check({name, "_mispred_cnt"}, bp_if.mispredict_count_o, mis);
    endtask

    task automatic check_mispredict(input string name, input logic redir,
                                    input logic [WIDTH-1:0] tgt);
        #1;
        check({name, "_pc_redirect"}, WIDTH'(bp_if.pc_redirect_o), WIDTH'(redir));
        check({name, "_mis_tgt"}, bp_if.mispredict_target_pc_o, tgt);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bp_if.PCF    = 32'h100;
        bp_if.en     = 1'b1;
        no_update();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // Reset state
        check_lookup("reset", 32'h100, 1'b0, 32'h0, 1'b0);
        check_counts("reset", 32'd0, 32'd0);
        check_mispredict("reset", 1'b0, 32'h0);

        // Taken branch at 0x100 not predicted: mispredict, allocate
        set_update(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        check_mispredict("alloc", 1'b1, 32'h200);
        check_lookup("alloc_same_cycle", 32'h100, 1'b0, 32'h0, 1'b0);
        next_cycle();
        no_update();
        check_lookup("alloc_next", 32'h100, 1'b1, 32'h200, 1'b1);
        check_counts("alloc_next", 32'd1, 32'd1);

        // Not taken, predicted taken: ctr 10 -> 01, fall-through redirect
        set_update(1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 1'b1, 32'h200);
        check_mispredict("nt1", 1'b1, 32'h104);
        check_lookup("nt1_suppressed", 32'h100, 1'b0, 32'h200, 1'b1);
        next_cycle();
        no_update();
        check_lookup("nt1_next", 32'h100, 1'b0, 32'h200, 1'b0);

        // Not taken, predicted not taken: no mispredict, ctr 01 -> 00
        set_update(1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 1'b0, 32'h0);
        check_mispredict("nt2", 1'b0, 32'h0);
        next_cycle();
        no_update();
        check_lookup("nt2_next", 32'h100, 1'b0, 32'h200, 1'b0);
        check_counts("nt2_next", 32'd3, 32'd2);

        // Alias: 0x140 shares index 0 with 0x100 and evicts it
        set_update(1'b1, 32'h140, 1'b1, 32'h180, 1'b0, 1'b0, 32'h0);
        check_mispredict("alias", 1'b1, 32'h180);
        next_cycle();
        no_update();
        check_lookup("alias_old", 32'h100, 1'b0, 32'h0, 1'b0);
        check_lookup("alias_new", 32'h140, 1'b1, 32'h180, 1'b1);
        check_counts("alias", 32'd4, 32'd3);

        // Correct prediction: counts branch only
        set_update(1'b1, 32'h140, 1'b1, 32'h180, 1'b0, 1'b1, 32'h180);
        check_mispredict("correct", 1'b0, 32'h0);
        next_cycle();
        no_update();
        #1;
        check_counts("correct", 32'd5, 32'd3);

        // Direction right, target wrong: mispredict and retarget
        set_update(1'b1, 32'h140, 1'b1, 32'h1C0, 1'b0, 1'b1, 32'h180);
        check_mispredict("wrong_tgt", 1'b1, 32'h1C0);
        next_cycle();
        no_update();
        check_lookup("wrong_tgt_next", 32'h140, 1'b1, 32'h1C0, 1'b1);
        check_counts("wrong_tgt", 32'd6, 32'd4);

        // Jalr with misaligned target: stored target is aligned
        set_update(1'b1, 32'h300, 1'b1, 32'h403, 1'b1, 1'b0, 32'h0);
        check_mispredict("jalr", 1'b1, 32'h400);
        next_cycle();
        no_update();
        check_lookup("jalr_next", 32'h300, 1'b1, 32'h400, 1'b1);
        check_counts("jalr", 32'd7, 32'd5);

        // Both redirects at once: mispredict wins (0x140 now misses, no change)
        set_update(1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1C0);
        check_lookup("both_redir", 32'h300, 1'b0, 32'h400, 1'b1);
        check_mispredict("both_redir", 1'b1, 32'h144);
        next_cycle();
        no_update();

        // Stall: lookup still runs, redirect forced off
        bp_if.en = 1'b0;
        check_lookup("stall", 32'h300, 1'b0, 32'h400, 1'b1);
        check_counts("stall", 32'd8, 32'd6);

        // Not-taken on a jump entry lowers ctr, jump still predicts taken
        set_update(1'b1, 32'h300, 1'b0, 32'h400, 1'b1, 1'b1, 32'h400);
        check_mispredict("jump_nt", 1'b1, 32'h304);
        next_cycle();
        no_update();
        bp_if.en = 1'b1;
        check_lookup("jump_nt_next", 32'h300, 1'b1, 32'h400, 1'b1);
        check_counts("jump_nt", 32'd9, 32'd7);

        // Reset mid-operation with an update present: combinational redirect only
        rst_n = 1'b0;
        set_update(1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
        check_mispredict("rst_upd", 1'b1, 32'h500);
        next_cycle();
        rst_n = 1'b1;
        no_update();
        check_lookup("post_rst", 32'h300, 1'b0, 32'h0, 1'b0);
        check_counts("post_rst", 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
